// File: rtl/bs_pkg.sv
// Shared types and helpers for the barrel-shifter sweep generator.
package bs_pkg;

    // Width of a shift amount for a given data width; never narrower than one bit.
    function automatic int sa_width(input int dw);
        return ($clog2(dw) > 0) ? $clog2(dw) : 1;
    endfunction

    // Default configuration, matching the 32-bit shifter.
    localparam int BS_DATA_WIDTH = 32;
    localparam int BS_MAX_COUNT  = 256;
    localparam int BS_SA_WIDTH   = sa_width(BS_DATA_WIDTH);
    localparam int BS_CNT_WIDTH  = $clog2(BS_MAX_COUNT + 1);

    // One sweep command in the default configuration.
    typedef struct packed {
        logic [BS_DATA_WIDTH-1:0] data;
        logic [BS_SA_WIDTH-1:0]   start;
        logic [BS_SA_WIDTH-1:0]   step;
        logic [BS_CNT_WIDTH-1:0]  count;
    } bs_cmd_t;

    // IDLE: nothing active; RUN: active only; RUN_Q: active plus a pending command.
    typedef enum logic [1:0] {
        SWEEP_IDLE  = 2'd0,
        SWEEP_RUN   = 2'd1,
        SWEEP_RUN_Q = 2'd2
    } bs_sweep_state_e;

endpackage

// File: rtl/bs_cmd_slot.sv
// A single registered command entry with a valid flag; load wins over clear.
module bs_cmd_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_cmd,
    output logic             valid,
    output logic [WIDTH-1:0] cmd
);

    // Capture a new entry on load, otherwise drop it on clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            cmd   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            cmd   <= load_cmd;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/bs_sweep_gen.sv
// Sweep command expander: turns (data, start, step, count) commands into a
// stream of (data_in, shift_amount) beats for the barrel shifter.
module bs_sweep_gen
    import bs_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_COUNT  = 256,
    localparam int SA_WIDTH   = sa_width(DATA_WIDTH),
    localparam int CNT_WIDTH  = $clog2(MAX_COUNT + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [SA_WIDTH-1:0]   cmd_start,
    input  logic [SA_WIDTH-1:0]   cmd_step,
    input  logic [CNT_WIDTH-1:0]  cmd_count,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic [SA_WIDTH-1:0]   shift_amount,
    output logic                  out_last,
    output logic                  busy
);

    localparam int ACT_W  = DATA_WIDTH + SA_WIDTH;
    localparam int PEND_W = DATA_WIDTH + 2 * SA_WIDTH + CNT_WIDTH;
    localparam logic [SA_WIDTH:0] DW_EXT = (SA_WIDTH + 1)'(DATA_WIDTH);

    // Values below 2*DATA_WIDTH fold into range with one conditional subtract.
    function automatic logic [SA_WIDTH-1:0] mod_reduce(input logic [SA_WIDTH:0] v);
        return (v >= DW_EXT) ? SA_WIDTH'(v - DW_EXT) : SA_WIDTH'(v);
    endfunction

    bs_sweep_state_e state;

    logic                  act_valid;
    logic                  pend_valid;
    logic [ACT_W-1:0]      act_load_cmd;
    logic [ACT_W-1:0]      act_cmd;
    logic [PEND_W-1:0]     pend_load_cmd;
    logic [PEND_W-1:0]     pend_cmd;
    logic [DATA_WIDTH-1:0] pend_data;
    logic [SA_WIDTH-1:0]   pend_start;
    logic [SA_WIDTH-1:0]   pend_step;
    logic [CNT_WIDTH-1:0]  pend_count;
    logic [SA_WIDTH-1:0]   act_step;
    logic [SA_WIDTH-1:0]   new_start;
    logic [SA_WIDTH-1:0]   new_step;
    logic [SA_WIDTH-1:0]   load_start;
    logic [CNT_WIDTH-1:0]  load_count;
    logic [SA_WIDTH-1:0]   next_shift;
    logic [CNT_WIDTH-1:0]  remaining;
    logic                  accept;
    logic                  accept_nz;
    logic                  beat_hs;
    logic                  last_hs;
    logic                  load_new_active;
    logic                  load_pending;
    logic                  promote;
    logic                  act_load;
    logic                  act_clear;

    // Status is decoded purely from registered slot state.
    assign cmd_ready = !pend_valid;
    assign busy      = act_valid || pend_valid;
    assign out_valid = act_valid;

    // Incoming command, folded into range before it is stored anywhere.
    assign accept    = cmd_valid && cmd_ready;
    assign accept_nz = accept && (cmd_count != '0);
    assign new_start = mod_reduce({1'b0, cmd_start});
    assign new_step  = mod_reduce({1'b0, cmd_step});

    // Beat handshakes and slot routing.
    assign beat_hs         = act_valid && out_ready;
    assign last_hs         = beat_hs && out_last;
    assign load_new_active = accept_nz && ((state == SWEEP_IDLE) ||
                                           ((state == SWEEP_RUN) && last_hs));
    assign load_pending    = accept_nz && !load_new_active;
    assign promote         = last_hs && (state == SWEEP_RUN_Q);
    assign act_load        = load_new_active || promote;
    assign act_clear       = last_hs && !act_load;

    // The active slot takes either the queued command or the one arriving now.
    assign {pend_data, pend_start, pend_step, pend_count} = pend_cmd;
    assign pend_load_cmd = {cmd_data, new_start, new_step, cmd_count};
    assign act_load_cmd  = promote ? {pend_data, pend_step} : {cmd_data, new_step};
    assign load_start    = promote ? pend_start : new_start;
    assign load_count    = promote ? pend_count : cmd_count;
    assign {data_in, act_step} = act_cmd;

    assign next_shift = mod_reduce({1'b0, shift_amount} + {1'b0, act_step});

    bs_cmd_slot #(.WIDTH(ACT_W)) u_active (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (act_load),
        .clear    (act_clear),
        .load_cmd (act_load_cmd),
        .valid    (act_valid),
        .cmd      (act_cmd)
    );

    bs_cmd_slot #(.WIDTH(PEND_W)) u_pending (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load_pending),
        .clear    (promote),
        .load_cmd (pend_load_cmd),
        .valid    (pend_valid),
        .cmd      (pend_cmd)
    );

    // FSM plus beat counters; out_last is precomputed so it is registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= SWEEP_IDLE;
            shift_amount <= '0;
            remaining    <= '0;
            out_last     <= 1'b0;
        end else begin
            if (act_load) begin
                shift_amount <= load_start;
                remaining    <= load_count;
                out_last     <= (load_count == CNT_WIDTH'(1));
            end else if (beat_hs) begin
                shift_amount <= next_shift;
                remaining    <= remaining - CNT_WIDTH'(1);
                out_last     <= (remaining == CNT_WIDTH'(2));
            end

            case (state)
                SWEEP_IDLE: begin
                    if (accept_nz) state <= SWEEP_RUN;
                end
                SWEEP_RUN: begin
                    if (last_hs) begin
                        if (!accept_nz) state <= SWEEP_IDLE;
                    end else if (accept_nz) begin
                        state <= SWEEP_RUN_Q;
                    end
                end
                SWEEP_RUN_Q: begin
                    if (last_hs) state <= SWEEP_RUN;
                end
                default: state <= SWEEP_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bs_sweep_gen.sv
// Scoreboard bench for bs_sweep_gen: a 32-bit instance for the main sweeps and
// a 24-bit instance for modulo reduction of start/step.
module tb_bs_sweep_gen;
    import bs_pkg::*;

    typedef struct {
        logic [31:0] data;
        int          shift;
        bit          last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        cmd_valid, cmd_ready, out_valid, out_ready, out_last, busy;
    logic [31:0] cmd_data, data_in;
    logic [4:0]  cmd_start, cmd_step, shift_amount;
    logic [8:0]  cmd_count;

    logic        cmd_valid24, cmd_ready24, out_valid24, out_ready24, out_last24, busy24;
    logic [23:0] cmd_data24, data_in24;
    logic [4:0]  cmd_start24, cmd_step24, shift_amount24;
    logic [8:0]  cmd_count24;

    exp_t exp_q[$];
    exp_t exp24_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   beat_total = 0;
    int   last_beat_cyc = 0;

    bs_sweep_gen #(.DATA_WIDTH(32), .MAX_COUNT(256)) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_data     (cmd_data),
        .cmd_start    (cmd_start),
        .cmd_step     (cmd_step),
        .cmd_count    (cmd_count),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_in      (data_in),
        .shift_amount (shift_amount),
        .out_last     (out_last),
        .busy         (busy)
    );

    bs_sweep_gen #(.DATA_WIDTH(24), .MAX_COUNT(256)) u_dut24 (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid24),
        .cmd_ready    (cmd_ready24),
        .cmd_data     (cmd_data24),
        .cmd_start    (cmd_start24),
        .cmd_step     (cmd_step24),
        .cmd_count    (cmd_count24),
        .out_valid    (out_valid24),
        .out_ready    (out_ready24),
        .data_in      (data_in24),
        .shift_amount (shift_amount24),
        .out_last     (out_last24),
        .busy         (busy24)
    );

    // Cycle counter used to check that beats come out back to back.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expectBeat(input bit use24, input logic [31:0] d, input int sh, input bit last);
        exp_t e;
        e.data  = d;
        e.shift = sh;
        e.last  = last;
        if (use24) exp24_q.push_back(e);
        else       exp_q.push_back(e);
    endtask

    // Present a command and hold it until the DUT takes it; returns the accept cycle.
    task automatic applyStimulus(input bs_cmd_t c, input bit use24, output int acc_cyc);
        int tries;
        bit rdy;
        tries = 0;
        rdy   = 1'b0;
        if (use24) begin
            cmd_valid24 = 1'b1;
            cmd_data24  = c.data[23:0];
            cmd_start24 = c.start;
            cmd_step24  = c.step;
            cmd_count24 = c.count;
        end else begin
            cmd_valid = 1'b1;
            cmd_data  = c.data;
            cmd_start = c.start;
            cmd_step  = c.step;
            cmd_count = c.count;
        end
        while (!rdy && tries < 50) begin
            @(negedge clk);
            rdy = use24 ? cmd_ready24 : cmd_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        cmd_valid   = 1'b0;
        cmd_valid24 = 1'b0;
        acc_cyc     = cyc;
        checkOutput("cmd_accept", 64'(rdy), 64'd1);
    endtask

    // Wait (bounded) until every expected beat has been seen and both DUTs are idle.
    task automatic waitDrain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp24_q.size() != 0 || busy || busy24) && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("drain_pending", 64'(exp_q.size() + exp24_q.size()), 64'd0);
    endtask

    // Monitor for the 32-bit instance: compare every handshaked beat.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            beat_total++;
            last_beat_cyc = cyc;
            if (exp_q.size() == 0) begin
                checkOutput("beat32_unexpected", 64'(shift_amount), 64'hFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("beat32", 64'({data_in, shift_amount, out_last}),
                            64'({e.data, 5'(e.shift), e.last}));
            end
        end
    end

    // Monitor for the 24-bit instance.
    always @(negedge clk) begin
        if (reset_n && out_valid24 && out_ready24) begin
            if (exp24_q.size() == 0) begin
                checkOutput("beat24_unexpected", 64'(shift_amount24), 64'hFFFF);
            end else begin
                exp_t e;
                logic [23:0] d24;
                e = exp24_q.pop_front();
                d24 = e.data[23:0];
                checkOutput("beat24", 64'({data_in24, shift_amount24, out_last24}),
                            64'({d24, 5'(e.shift), e.last}));
            end
        end
    end

    initial begin
        bs_cmd_t c;
        int      acc;
        int      n0;

        reset_n     = 1'b0;
        cmd_valid   = 1'b0; cmd_data   = '0; cmd_start   = '0; cmd_step   = '0; cmd_count   = '0;
        cmd_valid24 = 1'b0; cmd_data24 = '0; cmd_start24 = '0; cmd_step24 = '0; cmd_count24 = '0;
        out_ready   = 1'b1;
        out_ready24 = 1'b1;

        #2;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_last", 64'(out_last), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_data_in", 64'(data_in), 64'd0);
        checkOutput("rst_shift", 64'(shift_amount), 64'd0);
        checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single sweep: shifts 0,1,2,3 on consecutive cycles, last on beat 4.
        $display("[TB] single sweep");
        expectBeat(0, 32'h8000_0001, 0, 0);
        expectBeat(0, 32'h8000_0001, 1, 0);
        expectBeat(0, 32'h8000_0001, 2, 0);
        expectBeat(0, 32'h8000_0001, 3, 1);
        c = '{data: 32'h8000_0001, start: 5'd0, step: 5'd1, count: 9'd4};
        applyStimulus(c, 0, acc);
        waitDrain();
        checkOutput("single_contiguous", 64'(last_beat_cyc), 64'(acc + 3));
        checkOutput("single_valid_after", 64'(out_valid), 64'd0);

        // Wrap past the word width: 30, 1, 4.
        $display("[TB] wrap");
        expectBeat(0, 32'h1234_5678, 30, 0);
        expectBeat(0, 32'h1234_5678, 1, 0);
        expectBeat(0, 32'h1234_5678, 4, 1);
        c = '{data: 32'h1234_5678, start: 5'd30, step: 5'd3, count: 9'd3};
        applyStimulus(c, 0, acc);
        waitDrain();

        // Back-to-back: A(2) + B(3) + C(1) stream as six contiguous beats.
        $display("[TB] back-to-back");
        expectBeat(0, 32'h0000_AAAA, 5, 0);
        expectBeat(0, 32'h0000_AAAA, 7, 1);
        expectBeat(0, 32'h0000_BBBB, 31, 0);
        expectBeat(0, 32'h0000_BBBB, 0, 0);
        expectBeat(0, 32'h0000_BBBB, 1, 1);
        expectBeat(0, 32'h0000_CCCC, 10, 1);
        n0 = beat_total;
        c = '{data: 32'h0000_AAAA, start: 5'd5, step: 5'd2, count: 9'd2};
        applyStimulus(c, 0, acc);
        c = '{data: 32'h0000_BBBB, start: 5'd31, step: 5'd1, count: 9'd3};
        applyStimulus(c, 0, n0);
        n0 = beat_total - 1;
        @(negedge clk);
        checkOutput("b2b_cmd_ready_stalled", 64'(cmd_ready), 64'd0);
        checkOutput("b2b_busy", 64'(busy), 64'd1);
        c = '{data: 32'h0000_CCCC, start: 5'd10, step: 5'd7, count: 9'd1};
        applyStimulus(c, 0, n0);
        checkOutput("b2b_c_accept_cycle", 64'(n0), 64'(acc + 3));
        waitDrain();
        checkOutput("b2b_contiguous", 64'(last_beat_cyc), 64'(acc + 5));

        // Backpressure: out_ready 1,0,0,1 -> outputs frozen at the second beat.
        $display("[TB] backpressure");
        expectBeat(0, 32'hDEAD_BEEF, 7, 0);
        expectBeat(0, 32'hDEAD_BEEF, 16, 0);
        expectBeat(0, 32'hDEAD_BEEF, 25, 1);
        n0 = beat_total;
        c = '{data: 32'hDEAD_BEEF, start: 5'd7, step: 5'd9, count: 9'd3};
        applyStimulus(c, 0, acc);
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checkOutput("stall1_beat", 64'({out_valid, data_in, shift_amount, out_last}),
                    64'({1'b1, 32'hDEAD_BEEF, 5'd16, 1'b0}));
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("stall2_beat", 64'({out_valid, data_in, shift_amount, out_last}),
                    64'({1'b1, 32'hDEAD_BEEF, 5'd16, 1'b0}));
        @(posedge clk);
        #1 out_ready = 1'b1;
        waitDrain();
        checkOutput("stall_handshakes", 64'(beat_total - n0), 64'd3);

        // Zero count: accepted, nothing emitted, never busy.
        $display("[TB] zero count");
        c = '{data: 32'h5555_5555, start: 5'd3, step: 5'd1, count: 9'd0};
        applyStimulus(c, 0, acc);
        @(negedge clk);
        checkOutput("zero_busy", 64'(busy), 64'd0);
        checkOutput("zero_out_valid", 64'(out_valid), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("zero_busy_later", 64'(busy), 64'd0);

        // Reset mid-sweep: drop in-flight beats and never resume.
        $display("[TB] reset mid-sweep");
        expectBeat(0, 32'h0F0F_0F0F, 4, 0);
        c = '{data: 32'h0F0F_0F0F, start: 5'd4, step: 5'd4, count: 9'd5};
        applyStimulus(c, 0, acc);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("rst_mid_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
        checkOutput("rst_mid_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("rst_after_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_after_busy", 64'(busy), 64'd0);
        checkOutput("rst_after_expect_q", 64'(exp_q.size()), 64'd0);

        // Sweep after reset still works.
        expectBeat(0, 32'hCAFE_F00D, 31, 0);
        expectBeat(0, 32'hCAFE_F00D, 30, 1);
        c = '{data: 32'hCAFE_F00D, start: 5'd31, step: 5'd31, count: 9'd2};
        applyStimulus(c, 0, acc);
        waitDrain();

        // 24-bit instance: start/step reduction modulo 24.
        $display("[TB] 24-bit reduction");
        expectBeat(1, 32'h00AB_CDEF, 23, 0);
        expectBeat(1, 32'h00AB_CDEF, 1, 0);
        expectBeat(1, 32'h00AB_CDEF, 3, 1);
        c = '{data: 32'h00AB_CDEF, start: 5'd23, step: 5'd2, count: 9'd3};
        applyStimulus(c, 1, acc);
        waitDrain();
        expectBeat(1, 32'h0012_3456, 1, 0);
        expectBeat(1, 32'h0012_3456, 6, 1);
        c = '{data: 32'h0012_3456, start: 5'd25, step: 5'd5, count: 9'd2};
        applyStimulus(c, 1, acc);
        waitDrain();
        expectBeat(1, 32'h0065_4321, 0, 0);
        expectBeat(1, 32'h0065_4321, 2, 1);
        c = '{data: 32'h0065_4321, start: 5'd0, step: 5'd26, count: 9'd2};
        applyStimulus(c, 1, acc);
        waitDrain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
